wb_port_sched: RTL and testbench
================================

# wb_port_sched

Write-port scheduler for the general-register file. It shares the single GPR write port between two sources. The first is the in-order pipeline write-back stage, which produces the selected `wd_wb` value each cycle. The second is the multi-cycle multiply/divide unit (MDU), which retires results at arbitrary times. Pipeline write-back always wins the port. MDU results wait in a small FIFO and drain on idle port cycles. A lookup port lets the decode stage stall on, or forward from, queued MDU results.

## Interface
- `DEPTH`, 2, MDU result FIFO entries (power of two, ≥2)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `we_wb`  in  1  pipeline WB write request
- `waddr_wb`  in  5  pipeline WB destination register
- `wd_wb`  in  32  pipeline WB data
- `mdu_valid`  in  1  MDU result valid
- `mdu_waddr`  in  5  MDU destination register
- `mdu_wdata`  in  32  MDU result
- `mdu_ready`  out  1  FIFO can accept (count < DEPTH)
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  5  register-file write address (registered)
- `rf_wdata`  out  32  register-file write data (registered)
- `lk_addr`  in  5  decode-stage lookup address
- `lk_hit`  out  1  a live FIFO entry targets `lk_addr` (combinational)
- `lk_data`  out  32  data of the newest live matching entry; 0 when no hit
- `busy`  out  1  FIFO holds at least one live entry

## Operation
- Port grant, evaluated each cycle:
  - Pipeline write: when `we_wb`=1 and `waddr_wb`≠0.
  - Otherwise the oldest live FIFO entry pops and is written.
  - Otherwise no write.
- Writes to $0 are discarded and never consume the port. A pipeline write to $0 counts as an idle cycle.
- FIFO push: when `mdu_valid`=1 and `mdu_ready`=1. If `mdu_waddr`=0, the result is accepted and dropped, not pushed. `mdu_valid` while `mdu_ready`=0 is a protocol violation; the MDU must hold its result.
- WAW kill: a granted pipeline write to address A clears the live bit of every FIFO entry whose address is A, including an entry pushed in the same cycle. Killed entries still occupy slots and pop without writing, taking a port cycle with `rf_we`=0. This keeps program order, because the pipeline instruction is younger than the queued MDU result.
- Lookup: combinational compare of `lk_addr` against live entries; the newest match wins. `lk_addr`=0 never hits.
- State: circular buffer of {live, addr, data} × DEPTH, plus read pointer, write pointer and count. The count spans 0..DEPTH, with one extra bit so that full and empty are distinguishable.

## Timing
- Latency is one cycle from a granted request to `rf_we`/`rf_waddr`/`rf_wdata`.
- FIFO-to-port latency is at least two cycles: push in cycle N, earliest pop in N+1, write visible in N+2.
- `mdu_ready` comes only from the registered count. When full, there is no push even if a pop happens in the same cycle. Ready rises the cycle after the count drops.
- Simultaneous push and pop leave the count unchanged and advance both pointers.
- Pointers wrap modulo DEPTH.
- Reset (`rst_n`=0 at an edge), including mid-operation:
  - Outputs: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `mdu_ready`=1, `busy`=0, `lk_hit`=0, `lk_data`=0.
  - Internal: pointers and count are cleared, all live bits are cleared, and queued results are lost.
  - Inputs are ignored during that cycle.

## Structure
- Shared package holds `REG_W`=5, `DATA_W`=32, `REG_ZERO`=5'd0, and the FIFO entry struct {live, addr, data}.
- One sub-module, `wb_result_fifo`: circular buffer with push/pop, per-entry kill-by-address, and the newest-match lookup. The top module holds the grant logic and the output registers.

## Test plan
- Idle port: MDU pushes $8=0x1234 with no pipeline traffic → `rf_we`=1, `rf_waddr`=8, `rf_wdata`=0x1234 two cycles after the push; `busy` returns to 0.
- Contention: `we_wb`=1 with $3=0xAAAA for 3 cycles while the MDU pushes $9=0x55 → 3 pipeline writes, then the $9 write on the 4th output cycle.
- Full: pipeline writes every cycle, MDU pushes $4 then $5 → `mdu_ready`=0 after 2 pushes; after the pipeline goes idle, writes occur in order $4, $5 and `mdu_ready` returns to 1.
- WAW kill: queue $7=0x11; pipeline writes $7=0x22 → only 0x22 is ever written; the killed slot pops with `rf_we`=0.
- Lookup: queue $6=0x1 then $6=0x2 → `lk_addr`=6 gives `lk_hit`=1, `lk_data`=0x2; `lk_addr`=0 gives `lk_hit`=0.
- Reset mid-operation: assert `rst_n`=0 with 2 entries queued → the next cycle shows `busy`=0, `mdu_ready`=1, `rf_we`=0, and no queued write ever appears.

Source files
------------

// File: rtl/wb_port_sched_pkg.sv
// Shared types and constants for the GPR write-port scheduler.
package wb_port_sched_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // One queued MDU result; live drops when the entry is killed or popped
    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of MDU results with kill-by-address and newest-match lookup.
// A killed entry keeps its slot and count until it is popped, so program
// order is preserved; only its live bit is cleared.
module wb_result_fifo
    import wb_port_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_W-1:0]  push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill,
    input  logic [REG_W-1:0]  kill_addr,
    input  logic [REG_W-1:0]  lk_addr,
    output logic              head_live,
    output logic [REG_W-1:0]  head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data,
    output logic              busy
);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] lk_idx;

    assign head_live = mem[rd_ptr].live;
    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;

    // Buffer update: kill matching entries, retire the head, append the new result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && (mem[i].addr == kill_addr)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                mem[wr_ptr].live <= !(kill && (push_addr == kill_addr));
                mem[wr_ptr].addr <= push_addr;
                mem[wr_ptr].data <= push_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk entries oldest to newest so the last live match (the newest) wins
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr + PTR_W'(i);
            if (mem[lk_idx].live && (mem[lk_idx].addr == lk_addr) &&
                (lk_addr != REG_ZERO)) begin
                lk_hit  = 1'b1;
                lk_data = mem[lk_idx].data;
            end
        end
    end

    // Busy reflects live entries only; killed-but-unpopped slots do not count
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | mem[i].live;
        end
    end

endmodule

// File: rtl/wb_port_sched.sv
// GPR write-port scheduler: pipeline write-back always owns the port, queued
// MDU results drain on cycles the pipeline leaves idle (including $0 writes).
module wb_port_sched
    import wb_port_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_wb,
    input  logic [REG_W-1:0]  waddr_wb,
    input  logic [DATA_W-1:0] wd_wb,
    input  logic              mdu_valid,
    input  logic [REG_W-1:0]  mdu_waddr,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [REG_W-1:0]  lk_addr,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              grant_wb;
    logic              pop;
    logic              push;
    logic              head_live;
    logic [REG_W-1:0]  head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  count;

    // Ready depends only on the registered count, so a full FIFO refuses a
    // push even in a cycle where it also pops
    assign mdu_ready = (count < CNT_W'(DEPTH));

    // Port arbitration: pipeline first, then the FIFO head; $0 never consumes the port
    always_comb begin
        grant_wb = we_wb && (waddr_wb != REG_ZERO);
        pop      = !grant_wb && (count != '0);
        push     = mdu_valid && mdu_ready && (mdu_waddr != REG_ZERO);
    end

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (mdu_waddr),
        .push_data (mdu_wdata),
        .pop       (pop),
        .kill      (grant_wb),
        .kill_addr (waddr_wb),
        .lk_addr   (lk_addr),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data),
        .busy      (busy)
    );

    // Register the granted write; a popped killed entry yields an empty cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_wb) begin
            rf_we    <= 1'b1;
            rf_waddr <= waddr_wb;
            rf_wdata <= wd_wb;
        end else if (pop && head_live) begin
            rf_we    <= 1'b1;
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
        end else begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end
    end

endmodule

// File: tb/tb_wb_port_sched.sv
// Table-driven bench for wb_port_sched: each vector is held for one clock and
// the outputs are compared 1 time unit after the rising edge.
module tb_wb_port_sched;

    logic        clk;
    logic        rst_n;
    logic        we_wb;
    logic [4:0]  waddr_wb;
    logic [31:0] wd_wb;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic        busy;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic        rst_n;
        logic        we_wb;
        logic [4:0]  waddr_wb;
        logic [31:0] wd_wb;
        logic        mdu_valid;
        logic [4:0]  mdu_waddr;
        logic [31:0] mdu_wdata;
        logic [4:0]  lk_addr;
        logic        x_rf_we;
        logic [4:0]  x_rf_waddr;
        logic [31:0] x_rf_wdata;
        logic        x_ready;
        logic        x_busy;
        logic        x_hit;
        logic [31:0] x_lk_data;
    } vec_t;

    vec_t vecs[$];

    wb_port_sched #(
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_wb     (we_wb),
        .waddr_wb  (waddr_wb),
        .wd_wb     (wd_wb),
        .mdu_valid (mdu_valid),
        .mdu_waddr (mdu_waddr),
        .mdu_wdata (mdu_wdata),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .lk_addr   (lk_addr),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data),
        .busy      (busy)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic [4:0] la,
        input logic xwe, input logic [4:0] xa, input logic [31:0] xd,
        input logic xr, input logic xb, input logic xh, input logic [31:0] xl);
        vec_t v;
        v.rst_n = r;       v.we_wb = we;      v.waddr_wb = wa;   v.wd_wb = wd;
        v.mdu_valid = mv;  v.mdu_waddr = ma;  v.mdu_wdata = md;  v.lk_addr = la;
        v.x_rf_we = xwe;   v.x_rf_waddr = xa; v.x_rf_wdata = xd;
        v.x_ready = xr;    v.x_busy = xb;     v.x_hit = xh;      v.x_lk_data = xl;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one vector's inputs, clock once, and land just after the edge
    task automatic applyStimulus(input vec_t v);
        rst_n     = v.rst_n;
        we_wb     = v.we_wb;
        waddr_wb  = v.waddr_wb;
        wd_wb     = v.wd_wb;
        mdu_valid = v.mdu_valid;
        mdu_waddr = v.mdu_waddr;
        mdu_wdata = v.mdu_wdata;
        lk_addr   = v.lk_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d_rf_we", idx),     32'(rf_we),     32'(v.x_rf_we));
        checkOutput($sformatf("v%0d_rf_waddr", idx),  32'(rf_waddr),  32'(v.x_rf_waddr));
        checkOutput($sformatf("v%0d_rf_wdata", idx),  rf_wdata,       v.x_rf_wdata);
        checkOutput($sformatf("v%0d_mdu_ready", idx), 32'(mdu_ready), 32'(v.x_ready));
        checkOutput($sformatf("v%0d_busy", idx),      32'(busy),      32'(v.x_busy));
        checkOutput($sformatf("v%0d_lk_hit", idx),    32'(lk_hit),    32'(v.x_hit));
        checkOutput($sformatf("v%0d_lk_data", idx),   lk_data,        v.x_lk_data);
    endtask

    // Vector table followed by a bounded drain-order sequence
    initial begin
        logic [4:0]  got_addr [2];
        logic [31:0] got_data [2];
        int          got;

        rst_n = 1'b0; we_wb = 1'b0; waddr_wb = '0; wd_wb = '0;
        mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0; lk_addr = '0;

        //            rst we wa  wd        mv ma  md        lk | we  a   d         rdy bsy hit lkd
        // reset
        vecs.push_back(mk(0, 0, 0,  0,        0, 0,  0,        0,   0, 0,  0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,        0, 0,  0,        0,   0, 0,  0,        1, 0, 0, 0));
        // idle port: push $8, written two cycles later
        vecs.push_back(mk(1, 0, 0,  0,        1, 8,  'h1234,   8,   0, 0,  0,        1, 1, 1, 'h1234));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        8,   1, 8,  'h1234,   1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        0,   0, 0,  0,        1, 0, 0, 0));
        // contention: three pipeline writes then the $9 result
        vecs.push_back(mk(1, 1, 3,  'hAAAA,   1, 9,  'h55,     9,   1, 3,  'hAAAA,   1, 1, 1, 'h55));
        vecs.push_back(mk(1, 1, 3,  'hAAAA,   0, 0,  0,        9,   1, 3,  'hAAAA,   1, 1, 1, 'h55));
        vecs.push_back(mk(1, 1, 3,  'hAAAA,   0, 0,  0,        9,   1, 3,  'hAAAA,   1, 1, 1, 'h55));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        9,   1, 9,  'h55,     1, 0, 0, 0));
        // full: two pushes under pipeline traffic, then drain; valid while full is refused
        vecs.push_back(mk(1, 1, 1,  'h10,     1, 4,  'h44,     4,   1, 1,  'h10,     1, 1, 1, 'h44));
        vecs.push_back(mk(1, 1, 1,  'h11,     1, 5,  'h55,     5,   1, 1,  'h11,     0, 1, 1, 'h55));
        vecs.push_back(mk(1, 1, 1,  'h12,     0, 0,  0,        4,   1, 1,  'h12,     0, 1, 1, 'h44));
        vecs.push_back(mk(1, 0, 0,  0,        1, 10, 'h99,     0,   1, 4,  'h44,     1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        5,   1, 5,  'h55,     1, 0, 0, 0));
        // WAW kill: queued $7 overtaken by pipeline $7, killed slot pops silently
        vecs.push_back(mk(1, 0, 0,  0,        1, 7,  'h11,     7,   0, 0,  0,        1, 1, 1, 'h11));
        vecs.push_back(mk(1, 1, 7,  'h22,     0, 0,  0,        7,   1, 7,  'h22,     1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        7,   0, 0,  0,        1, 0, 0, 0));
        // same-cycle push and kill of $12
        vecs.push_back(mk(1, 1, 12, 'h77,     1, 12, 'h66,     12,  1, 12, 'h77,     1, 0, 0, 0));
        // dead pop together with a push of $13: count holds, pointers advance
        vecs.push_back(mk(1, 0, 0,  0,        1, 13, 'h13,     13,  0, 0,  0,        1, 1, 1, 'h13));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        13,  1, 13, 'h13,     1, 0, 0, 0));
        // lookup: two $6 entries straddling the pointer wrap, newest wins
        vecs.push_back(mk(1, 1, 2,  'h20,     1, 6,  'h1,      6,   1, 2,  'h20,     1, 1, 1, 'h1));
        vecs.push_back(mk(1, 1, 2,  'h21,     1, 6,  'h2,      6,   1, 2,  'h21,     0, 1, 1, 'h2));
        vecs.push_back(mk(1, 1, 2,  'h22,     0, 0,  0,        0,   1, 2,  'h22,     0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 31, 'h33,     0, 0,  0,        6,   1, 31, 'h33,     0, 1, 1, 'h2));
        // reset with two entries queued; queued writes never appear
        vecs.push_back(mk(0, 1, 3,  'h5,      1, 11, 'h5,      6,   0, 0,  0,        1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        6,   0, 0,  0,        1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0,        0, 0,  0,        6,   0, 0,  0,        1, 0, 0, 0));
        // $0 writes: pipeline $0 is idle, MDU $0 is dropped
        vecs.push_back(mk(1, 1, 0,  'hDEAD,   1, 0,  'hBEEF,   0,   0, 0,  0,        1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0,  'h1,      1, 14, 'h14,     14,  0, 0,  0,        1, 1, 1, 'h14));
        vecs.push_back(mk(1, 1, 0,  'h2,      0, 0,  0,        14,  1, 14, 'h14,     1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Hand sequence: fill under pipeline traffic, then drain in order
        applyStimulus(mk(1, 1, 1, 'hB0, 1, 20, 'hA0, 0,  0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 1, 1, 'hB1, 1, 21, 'hA1, 21, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("seq_ready_full", 32'(mdu_ready), 32'(0));
        checkOutput("seq_busy_full", 32'(busy), 32'(1));

        got = 0;
        got_addr[0] = '0; got_addr[1] = '0;
        got_data[0] = '0; got_data[1] = '0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            if (rf_we === 1'b1) begin
                if (got < 2) begin
                    got_addr[got] = rf_waddr;
                    got_data[got] = rf_wdata;
                end
                got++;
            end
        end
        checkOutput("seq_write_count", 32'(got), 32'(2));
        checkOutput("seq_first_addr", 32'(got_addr[0]), 32'(20));
        checkOutput("seq_first_data", got_data[0], 32'hA0);
        checkOutput("seq_second_addr", 32'(got_addr[1]), 32'(21));
        checkOutput("seq_second_data", got_data[1], 32'hA1);
        checkOutput("seq_ready_after", 32'(mdu_ready), 32'(1));
        checkOutput("seq_busy_after", 32'(busy), 32'(0));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
